// File: rtl/hc128_core.sv
// hc128_core: HC-128 stream cipher engine with P/Q tables, key/IV expansion, keyed init
// and a burst keystream generator. Each cipher step takes two cycles: update, then h() lookup.
module hc128_core #(
    parameter int unsigned BURST_WORDS = 1,
    parameter int unsigned INIT_STEPS  = 1024
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [127:0] key,
    input  logic [127:0] iv,
    input  logic         init,
    input  logic         next,
    output logic         ready,
    output logic [31:0]  s,
    output logic         s_valid
);
    typedef enum logic [2:0] {StIdle, StLoad, StExpand, StMix, StReady, StGen} state_e;

    state_e      r_state, w_state_next;
    logic [31:0] r_i;
    logic        r_phase;
    logic [15:0] r_burst;
    logic [31:0] r_upd;
    logic [15:0] r_hidx;
    logic [31:0] r_s;
    logic        r_svalid;
    logic [31:0] r_w [16];
    logic [31:0] r_p [512];
    logic [31:0] r_q [512];

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] f1(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] f2(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] g1(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z);
        return (rotr(x, 10) ^ rotr(z, 23)) + rotr(y, 8);
    endfunction

    function automatic logic [31:0] g2(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z);
        return (rotl(x, 10) ^ rotl(z, 23)) + rotl(y, 8);
    endfunction

    // Expansion datapath: window holds W[i-16..i-1]
    logic [31:0] w_w_new;
    logic [8:0]  w_exp_idx;
    assign w_w_new   = f2(r_w[14]) + r_w[9] + f1(r_w[1]) + r_w[0] + r_i;
    assign w_exp_idx = {~r_i[8], r_i[7:0]};

    // Step datapath
    logic        w_qhalf;
    logic [8:0]  w_j, w_j3, w_j10, w_j511, w_j12;
    logic [31:0] w_t_j, w_t3, w_t10, w_t511, w_g, w_h, w_word, w_wr_val;
    logic [15:0] w_hidx;
    logic        w_stepping, w_mix_last, w_burst_last;

    assign w_qhalf = r_i[9];
    assign w_j     = r_i[8:0];
    assign w_j3    = w_j - 9'd3;
    assign w_j10   = w_j - 9'd10;
    assign w_j511  = w_j + 9'd1;
    assign w_j12   = w_j - 9'd12;

    assign w_t_j  = w_qhalf ? r_q[w_j]    : r_p[w_j];
    assign w_t3   = w_qhalf ? r_q[w_j3]   : r_p[w_j3];
    assign w_t10  = w_qhalf ? r_q[w_j10]  : r_p[w_j10];
    assign w_t511 = w_qhalf ? r_q[w_j511] : r_p[w_j511];
    assign w_hidx = w_qhalf ? {r_q[w_j12][23:16], r_q[w_j12][7:0]}
                            : {r_p[w_j12][23:16], r_p[w_j12][7:0]};
    assign w_g    = w_qhalf ? g2(w_t3, w_t10, w_t511) : g1(w_t3, w_t10, w_t511);

    // h() always looks up the table that is not being updated
    assign w_h = w_qhalf ? (r_p[{1'b0, r_hidx[7:0]}] + r_p[{1'b1, r_hidx[15:8]}])
                         : (r_q[{1'b0, r_hidx[7:0]}] + r_q[{1'b1, r_hidx[15:8]}]);
    assign w_word   = w_h ^ r_upd;
    assign w_wr_val = (r_state == StMix) ? w_word : r_upd;

    assign w_stepping   = (r_state == StMix) || (r_state == StGen);
    assign w_mix_last   = (r_i == 32'(INIT_STEPS - 1));
    assign w_burst_last = (r_burst == 16'(BURST_WORDS - 1));

    always_ff @(posedge clk) begin
        if (reset) r_state <= StIdle;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:   w_state_next = StIdle;
            StLoad:   w_state_next = StExpand;
            StExpand: if (r_i == 32'd1279) w_state_next = (INIT_STEPS == 0) ? StReady : StMix;
            StMix:    if (r_phase && w_mix_last) w_state_next = StReady;
            StReady:  if (next && !r_svalid) w_state_next = StGen;
            StGen:    if (r_phase && w_burst_last) w_state_next = StReady;
            default:  w_state_next = StIdle;
        endcase
        if (init) w_state_next = StLoad;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_i      <= '0;
            r_phase  <= 1'b0;
            r_burst  <= '0;
            r_upd    <= '0;
            r_hidx   <= '0;
            r_s      <= '0;
            r_svalid <= 1'b0;
        end else begin
            r_svalid <= 1'b0;
            if (init) begin
                r_phase <= 1'b0;
            end else begin
                case (r_state)
                    StLoad:   r_i <= 32'd16;
                    StExpand: r_i <= (r_i == 32'd1279) ? '0 : r_i + 32'd1;
                    StMix, StGen: begin
                        r_phase <= ~r_phase;
                        if (!r_phase) begin
                            r_upd  <= w_t_j + w_g;
                            r_hidx <= w_hidx;
                        end else begin
                            r_i <= r_i + 32'd1;
                            if (r_state == StGen) begin
                                r_s      <= w_word;
                                r_svalid <= 1'b1;
                                r_burst  <= r_burst + 16'd1;
                            end else if (w_mix_last) begin
                                r_i <= '0;
                            end
                        end
                    end
                    StReady: begin
                        if (next && !r_svalid) begin
                            r_burst <= '0;
                            r_phase <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == StLoad) begin
            for (int k = 0; k < 4; k++) begin
                r_w[k]      <= key[32*k +: 32];
                r_w[k + 4]  <= key[32*k +: 32];
                r_w[k + 8]  <= iv[32*k +: 32];
                r_w[k + 12] <= iv[32*k +: 32];
            end
        end else if (r_state == StExpand) begin
            for (int k = 0; k < 15; k++) r_w[k] <= r_w[k + 1];
            r_w[15] <= w_w_new;
        end
    end

    // W[256..767] fill P, W[768..1279] fill Q; steps write back in their second cycle
    always_ff @(posedge clk) begin
        if (r_state == StExpand && r_i >= 32'd256) begin
            if (r_i < 32'd768) r_p[w_exp_idx] <= w_w_new;
            else               r_q[w_exp_idx] <= w_w_new;
        end else if (w_stepping && r_phase) begin
            if (w_qhalf) r_q[w_j] <= w_wr_val;
            else         r_p[w_j] <= w_wr_val;
        end
    end

    assign ready   = (r_state == StReady) && !r_svalid;
    assign s       = r_s;
    assign s_valid = r_svalid;

endmodule

// File: tb/tb_hc128_core.sv
// tb_hc128_core: drives hc128_core with known and random keys and checks every cycle
// against an algorithmic HC-128 model and a cycle-time expectation of ready/s_valid.
module tb_hc128_core;
    localparam int unsigned BW    = 7;
    localparam int unsigned INITS = 1024;
    localparam int          SETUP = 1 + 1264 + 2 * INITS;
    localparam int          NEVER = 32'h7fff_ffff;

    logic         clk = 1'b0;
    logic         reset, init, next;
    logic [127:0] key, iv;
    logic         ready, s_valid;
    logic [31:0]  s;

    hc128_core #(.BURST_WORDS(BW), .INIT_STEPS(INITS)) u_dut (
        .clk    (clk),
        .reset  (reset),
        .key    (key),
        .iv     (iv),
        .init   (init),
        .next   (next),
        .ready  (ready),
        .s      (s),
        .s_valid(s_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_checks = 0;
    int          n_fail   = 0;
    bit          chk_on   = 1'b0;
    int          rdy_from = NEVER;
    int          init_edge = 0;
    int          sq[$];
    logic [31:0] wq[$];
    logic [31:0] last_exp = '0;

    logic [31:0] mp [512];
    logic [31:0] mq [512];
    int unsigned mi;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x} >> n;
        return d[31:0];
    endfunction

    function automatic logic [31:0] rol(input logic [31:0] x, input int n);
        return ror(x, 32 - n);
    endfunction

    function automatic logic [31:0] mf1(input logic [31:0] x);
        return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] mf2(input logic [31:0] x);
        return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
    endfunction

    task automatic model_step(input bit mix, output logic [31:0] word);
        int unsigned j;
        logic [31:0] x;
        j = mi % 512;
        if ((mi % 1024) < 512) begin
            mp[j] = mp[j] + ((ror(mp[(j + 509) % 512], 10) ^ ror(mp[(j + 1) % 512], 23))
                             + ror(mp[(j + 502) % 512], 8));
            x = mp[(j + 500) % 512];
            word = (mq[x[7:0]] + mq[256 + int'(x[23:16])]) ^ mp[j];
            if (mix) mp[j] = word;
        end else begin
            mq[j] = mq[j] + ((rol(mq[(j + 509) % 512], 10) ^ rol(mq[(j + 1) % 512], 23))
                             + rol(mq[(j + 502) % 512], 8));
            x = mq[(j + 500) % 512];
            word = (mp[x[7:0]] + mp[256 + int'(x[23:16])]) ^ mq[j];
            if (mix) mq[j] = word;
        end
        mi++;
    endtask

    task automatic model_init(input logic [127:0] k, input logic [127:0] v);
        logic [31:0] w [1280];
        logic [31:0] d;
        for (int n = 0; n < 8; n++) begin
            w[n]     = k[32*(n%4) +: 32];
            w[n + 8] = v[32*(n%4) +: 32];
        end
        for (int n = 16; n < 1280; n++)
            w[n] = mf2(w[n-2]) + w[n-7] + mf1(w[n-15]) + w[n-16] + n;
        for (int n = 0; n < 512; n++) begin
            mp[n] = w[n + 256];
            mq[n] = w[n + 768];
        end
        mi = 0;
        for (int n = 0; n < int'(INITS); n++) model_step(1'b1, d);
        mi = 0;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // key/iv are held through the LOAD cycle and then scrambled
    task automatic do_init(input logic [127:0] k, input logic [127:0] v);
        key  = k;
        iv   = v;
        init = 1'b1;
        tick();
        init      = 1'b0;
        init_edge = cyc;
        rdy_from  = cyc + SETUP;
        sq.delete();
        wq.delete();
        model_init(k, v);
        tick();
        key = rand128();
        iv  = rand128();
    endtask

    task automatic do_burst(input bit hold, output int t0);
        logic [31:0] w;
        t0 = cyc;
        if (rdy_from == NEVER) begin
            n_checks++;
            n_fail++;
            $display("FAIL burst_request: got no pending setup, expected a keyed core");
            return;
        end
        while (cyc < rdy_from) tick();
        next = 1'b1;
        tick();
        if (!hold) next = 1'b0;
        t0 = cyc;
        for (int k = 0; k < int'(BW); k++) begin
            model_step(1'b0, w);
            wq.push_back(w);
            sq.push_back(t0 + 2 * k + 2);
        end
        rdy_from = t0 + 2 * int'(BW) + 1;
    endtask

    // Per-cycle compare against the expected strobe schedule and ready window
    initial begin
        logic exp_v;
        forever begin
            @(negedge clk);
            if (chk_on) begin
                exp_v = (sq.size() > 0) && (sq[0] == cyc);
                chk("s_valid", 32'(s_valid), 32'(exp_v));
                chk("ready", 32'(ready), 32'(cyc >= rdy_from));
                if (exp_v) begin
                    chk("s_word", s, wq[0]);
                    last_exp = wq[0];
                    void'(sq.pop_front());
                    void'(wq.pop_front());
                end else begin
                    chk("s_hold", s, last_exp);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test by %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] lit [4];
        int          t0;
        lit[0] = 32'h73150082;
        lit[1] = 32'h3bfd03a0;
        lit[2] = 32'hfb2fd77f;
        lit[3] = 32'haa63af0e;

        reset = 1'b1; init = 1'b0; next = 1'b0; key = '0; iv = '0;
        tick();
        chk_on = 1'b1;
        chk("reset_ready", 32'(ready), 32'd0);
        chk("reset_s_valid", 32'(s_valid), 32'd0);
        chk("reset_s", s, 32'd0);
        tick();
        reset = 1'b0;

        // next before any init must be ignored
        next = 1'b1;
        repeat (4) tick();
        next = 1'b0;
        repeat (2) tick();

        // all-zero key/iv vector, with a next pulse in the middle of MIX
        do_init('0, '0);
        while (cyc < init_edge + 2000) tick();
        next = 1'b1;
        repeat (3) tick();
        next = 1'b0;
        while (!ready && cyc < init_edge + 4000) tick();
        chk("setup_latency", 32'(cyc - init_edge), 32'd3313);
        do_burst(1'b0, t0);
        for (int k = 0; k < 4; k++) chk("model_vector", wq[k], lit[k]);
        for (int k = 0; k < 4; k++) begin
            while (cyc < t0 + 2 * k + 2) tick();
            @(negedge clk);
            chk("dut_vector", s, lit[k]);
        end

        // random key: 2002 words, with some bursts requested by a held-high next
        do_init(rand128(), rand128());
        for (int b = 0; b < 286; b++) begin
            do_burst((b % 20) >= 15, t0);
            if ((b % 20) < 15) repeat ($urandom_range(0, 2)) tick();
        end
        next = 1'b0;
        while (cyc < rdy_from) tick();

        // init after the 2nd word of a burst aborts it and rekeys
        do_init(rand128(), rand128());
        do_burst(1'b0, t0);
        while (cyc < t0 + 4) tick();
        do_init(rand128(), rand128());
        do_burst(1'b0, t0);
        while (cyc < rdy_from) tick();

        // reset during EXPAND, then the zero vector again
        do_init(rand128(), rand128());
        repeat (100) tick();
        reset = 1'b1;
        tick();
        reset    = 1'b0;
        rdy_from = NEVER;
        sq.delete();
        wq.delete();
        last_exp = '0;
        next = 1'b1;
        repeat (3) tick();
        next = 1'b0;
        do_init('0, '0);
        do_burst(1'b0, t0);
        while (cyc < t0 + 2) tick();
        @(negedge clk);
        chk("reset_vector_w0", s, lit[0]);
        while (cyc < rdy_from) tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
